axi4_buf_slice: RTL and testbench
=================================

AXI4_BUF_SLICE -- requirements
Module: axi4_buf_slice

Interface
REQ-001 Parameter AW, 32, address width for both AW and AR channels.
REQ-002 Parameter DW, 32, data width; strobe width is DW/8.
REQ-003 Parameter IW, 1, ID width for AWID, WID, BID, ARID and RID.
REQ-004 Parameter UW, 1, user width for all xUSER fields; minimum 1.
REQ-005 Parameters AWD, WD, BD, ARD, RD, each default 2, set the per-channel buffer depth: 0 = combinational pass-through, 1..16 = FIFO of that depth.
REQ-006 ACLK  input  1  single clock for all logic.
REQ-007 ARESET  input  1  reset, synchronous, active-high.
REQ-008 s  axi4_if.s modport  param  upstream port; the upstream master connects here.
REQ-009 m  axi4_if.m modport  param  downstream port; the downstream slave connects here.
REQ-010 lvl_aw, lvl_w, lvl_b, lvl_ar, lvl_r  output  5 each  current occupancy of each channel buffer.

Function
REQ-011 Channel directions: AW, W and AR flow s->m; B and R flow m->s.
REQ-012 Every payload field of a channel is carried unmodified, in order (ID, ADDR, REGION, LEN, SIZE, BURST, LOCK, CACHE, PROT, QOS, USER; DATA, STRB, LAST; RESP).
REQ-013 Depth 0: destination VALID = source VALID, source READY = destination READY, payload passes combinationally; lvl is 0.
REQ-014 Depth N>=1: source READY = (lvl < N) and is driven from registers only, with no combinational path from destination READY.
REQ-015 Depth N>=1: destination VALID = (lvl > 0), driven from registers; payload is the head entry, driven from registers.
REQ-016 Push occurs on source VALID&READY; pop occurs on destination VALID&READY; lvl is incremented by push and decremented by pop.
REQ-017 Latency, depth >=1: a beat accepted at edge k is presented with destination VALID high from edge k+1.
REQ-018 Full (lvl=N): source READY is low; a pop at the same edge frees the entry, and READY rises at the next edge.
REQ-019 Empty (lvl=0) with push: destination VALID rises the next cycle; there is no bypass of the same beat.
REQ-020 Simultaneous push and pop with 0<lvl<N: lvl is unchanged and order is preserved.
REQ-021 Read and write pointers are log2(N) bits and wrap modulo N; N that is not a power of two wraps explicitly at N-1 -> 0.
REQ-022 With ACLK running, throughput is one beat per cycle per channel when depth >=2 or depth=0.
REQ-023 Depth 1 sustains one beat per 2 cycles.
REQ-024 Destination VALID, once high, stays high and its payload stays stable until the beat is popped (AXI rule); a bench assertion checks this.
REQ-025 Channels are fully independent; there is no cross-channel ordering or ID tracking.

Reset
REQ-026 While ARESET is high at an edge: all lvl=0, pointers=0, all destination VALID=0, all source READY=0.
REQ-027 The first edge with ARESET low sets READY=1 for every buffered channel.
REQ-028 Reset asserted mid-burst discards all buffered beats and drives no partial beat afterwards.
REQ-029 Payload storage is not reset; it is don't-care while VALID=0.

Structure
REQ-030 Package axi4_pkg holds the BRESP/RRESP encodings (OKAY, EXOKAY, SLVERR, DECERR), the BURST encodings, and a function returning the packed payload width per channel given AW, DW, IW and UW.
REQ-031 Sub-module axi4_chan_fifo (parameters WIDTH and DEPTH) implements one channel; it is instantiated five times on packed payload vectors.
REQ-032 The depth-0 case is a generate branch inside axi4_chan_fifo.

Verification
REQ-033 Scenario: single AW beat, AWD=2, AWADDR=0x1000, AWLEN=3, AWID=1 -> m.AWVALID is high one cycle later with identical fields, and lvl_aw goes 0->1->0.
REQ-034 Scenario: W fill, WD=4, m.WREADY=0, four beats driven -> s.WREADY is low after the 4th accept and lvl_w=4; then m.WREADY=1 -> beats exit in order 0..3 and s.WREADY rises one cycle after the first pop.
REQ-035 Scenario: streaming R, RD=2, 64 beats with RDATA=index, both sides always ready -> 64 beats arrive in order, one per cycle after initial 1-cycle latency, RLAST only on beat 63.
REQ-036 Scenario: random VALID/READY on all five channels, depths {0,1,2,3,16}, 10k cycles -> scoreboard matches every channel in order; the REQ-024 stability assertion never fires.
REQ-037 Scenario: ARESET pulsed for 1 cycle with lvl_b=2 -> next cycle lvl_b=0 and m-side/s-side VALID=0; after release, the next pushed BRESP=SLVERR is the first beat delivered.
REQ-038 Scenario: depth-0 channel, AR -> s.ARREADY equals m.ARREADY in the same cycle and ARADDR=0xDEADBEEC passes with zero latency.

Source files
------------

// File: rtl/axi4_pkg.sv
// Shared AXI4 encodings and per-channel packed payload widths for the buffer slice.
package axi4_pkg;

  localparam int LVL_W     = 5;
  localparam int MAX_DEPTH = 16;

  // REGION + LEN + SIZE + BURST + LOCK + CACHE + PROT + QOS
  localparam int AX_FIXED_W = 4 + 8 + 3 + 2 + 1 + 4 + 3 + 4;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  typedef enum logic [2:0] {
    CH_AW = 3'd0,
    CH_W  = 3'd1,
    CH_B  = 3'd2,
    CH_AR = 3'd3,
    CH_R  = 3'd4
  } chan_e;

  function automatic int payload_width(chan_e ch, int aw, int dw, int iw, int uw);
    case (ch)
      CH_AW, CH_AR: return iw + aw + AX_FIXED_W + uw;
      CH_W:         return iw + dw + dw / 8 + 1 + uw;
      CH_B:         return iw + 2 + uw;
      default:      return iw + dw + 2 + 1 + uw;
    endcase
  endfunction

endpackage

// File: rtl/axi4_if.sv
// AXI4 bundle; modport s faces the upstream master, modport m faces the downstream slave.
interface axi4_if #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int IW = 1,
  parameter int UW = 1
);
  logic [IW-1:0]   AWID;
  logic [AW-1:0]   AWADDR;
  logic [3:0]      AWREGION;
  logic [7:0]      AWLEN;
  logic [2:0]      AWSIZE;
  logic [1:0]      AWBURST;
  logic            AWLOCK;
  logic [3:0]      AWCACHE;
  logic [2:0]      AWPROT;
  logic [3:0]      AWQOS;
  logic [UW-1:0]   AWUSER;
  logic            AWVALID;
  logic            AWREADY;

  logic [IW-1:0]   WID;
  logic [DW-1:0]   WDATA;
  logic [DW/8-1:0] WSTRB;
  logic            WLAST;
  logic [UW-1:0]   WUSER;
  logic            WVALID;
  logic            WREADY;

  logic [IW-1:0]   BID;
  logic [1:0]      BRESP;
  logic [UW-1:0]   BUSER;
  logic            BVALID;
  logic            BREADY;

  logic [IW-1:0]   ARID;
  logic [AW-1:0]   ARADDR;
  logic [3:0]      ARREGION;
  logic [7:0]      ARLEN;
  logic [2:0]      ARSIZE;
  logic [1:0]      ARBURST;
  logic            ARLOCK;
  logic [3:0]      ARCACHE;
  logic [2:0]      ARPROT;
  logic [3:0]      ARQOS;
  logic [UW-1:0]   ARUSER;
  logic            ARVALID;
  logic            ARREADY;

  logic [IW-1:0]   RID;
  logic [DW-1:0]   RDATA;
  logic [1:0]      RRESP;
  logic            RLAST;
  logic [UW-1:0]   RUSER;
  logic            RVALID;
  logic            RREADY;

  modport s (
    input  AWID, AWADDR, AWREGION, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, AWQOS,
           AWUSER, AWVALID,
    output AWREADY,
    input  WID, WDATA, WSTRB, WLAST, WUSER, WVALID,
    output WREADY,
    output BID, BRESP, BUSER, BVALID,
    input  BREADY,
    input  ARID, ARADDR, ARREGION, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARQOS,
           ARUSER, ARVALID,
    output ARREADY,
    output RID, RDATA, RRESP, RLAST, RUSER, RVALID,
    input  RREADY
  );

  modport m (
    output AWID, AWADDR, AWREGION, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, AWQOS,
           AWUSER, AWVALID,
    input  AWREADY,
    output WID, WDATA, WSTRB, WLAST, WUSER, WVALID,
    input  WREADY,
    input  BID, BRESP, BUSER, BVALID,
    output BREADY,
    output ARID, ARADDR, ARREGION, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARQOS,
           ARUSER, ARVALID,
    input  ARREADY,
    input  RID, RDATA, RRESP, RLAST, RUSER, RVALID,
    output RREADY
  );

endinterface

// File: rtl/axi4_chan_fifo.sv
// One valid/ready channel buffer: wire-through at DEPTH 0, otherwise a fully registered FIFO
// whose READY/VALID/head payload come straight from flops.
module axi4_chan_fifo
  import axi4_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             src_valid,
  output logic             src_ready,
  input  logic [WIDTH-1:0] src_data,
  output logic             dst_valid,
  input  logic             dst_ready,
  output logic [WIDTH-1:0] dst_data,
  output logic [LVL_W-1:0] lvl
);

  if (DEPTH == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;

    assign dst_valid = src_valid;
    assign src_ready = dst_ready;
    assign dst_data  = src_data;
    assign lvl       = '0;
  end else begin : g_fifo
    localparam int               PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0]    LAST_IDX = PW'(DEPTH - 1);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] lvl_q, lvl_d;
    logic             src_ready_q, src_ready_d;
    logic             dst_valid_q, dst_valid_d;
    logic             push, pop;

    assign push = src_valid & src_ready_q;
    assign pop  = dst_valid_q & dst_ready;

    always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      lvl_d    = lvl_q;

      if (push) begin
        mem_d[wr_ptr_q] = src_data;
        wr_ptr_d        = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = (rd_ptr_q == LAST_IDX) ? '0 : rd_ptr_q + 1'b1;
      end

      case ({push, pop})
        2'b10:   lvl_d = lvl_q + 1'b1;
        2'b01:   lvl_d = lvl_q - 1'b1;
        default: lvl_d = lvl_q;
      endcase

      // Flags are precomputed from the next level so both outputs stay pure flops.
      src_ready_d = (lvl_d < FULL_LVL);
      dst_valid_d = (lvl_d != '0);
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        wr_ptr_q    <= '0;
        rd_ptr_q    <= '0;
        lvl_q       <= '0;
        src_ready_q <= 1'b0;
        dst_valid_q <= 1'b0;
      end else begin
        wr_ptr_q    <= wr_ptr_d;
        rd_ptr_q    <= rd_ptr_d;
        lvl_q       <= lvl_d;
        src_ready_q <= src_ready_d;
        dst_valid_q <= dst_valid_d;
      end
    end

    // Storage carries no reset; entries are only observed while dst_valid is high.
    always_ff @(posedge clk) begin
      mem_q <= mem_d;
    end

    assign src_ready = src_ready_q;
    assign dst_valid = dst_valid_q;
    assign dst_data  = mem_q[rd_ptr_q];
    assign lvl       = lvl_q;
  end

endmodule

// File: rtl/axi4_buf_slice.sv
// AXI4 register slice: five independent channel buffers between an upstream master (s)
// and a downstream slave (m), each with its own depth.
module axi4_buf_slice
  import axi4_pkg::*;
#(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int IW  = 1,
  parameter int UW  = 1,
  parameter int AWD = 2,
  parameter int WD  = 2,
  parameter int BD  = 2,
  parameter int ARD = 2,
  parameter int RD  = 2
) (
  input  logic       ACLK,
  input  logic       ARESET,
  axi4_if.s          s,
  axi4_if.m          m,
  output logic [4:0] lvl_aw,
  output logic [4:0] lvl_w,
  output logic [4:0] lvl_b,
  output logic [4:0] lvl_ar,
  output logic [4:0] lvl_r
);

  localparam int AW_PW = payload_width(CH_AW, AW, DW, IW, UW);
  localparam int W_PW  = payload_width(CH_W,  AW, DW, IW, UW);
  localparam int B_PW  = payload_width(CH_B,  AW, DW, IW, UW);
  localparam int AR_PW = payload_width(CH_AR, AW, DW, IW, UW);
  localparam int R_PW  = payload_width(CH_R,  AW, DW, IW, UW);

  logic [AW_PW-1:0] aw_in, aw_out;
  logic [W_PW-1:0]  w_in,  w_out;
  logic [B_PW-1:0]  b_in,  b_out;
  logic [AR_PW-1:0] ar_in, ar_out;
  logic [R_PW-1:0]  r_in,  r_out;

  // Write address: s -> m
  assign aw_in = {s.AWID, s.AWADDR, s.AWREGION, s.AWLEN, s.AWSIZE, s.AWBURST, s.AWLOCK,
                  s.AWCACHE, s.AWPROT, s.AWQOS, s.AWUSER};
  assign {m.AWID, m.AWADDR, m.AWREGION, m.AWLEN, m.AWSIZE, m.AWBURST, m.AWLOCK,
          m.AWCACHE, m.AWPROT, m.AWQOS, m.AWUSER} = aw_out;

  axi4_chan_fifo #(.WIDTH(AW_PW), .DEPTH(AWD)) u_aw (
    .clk       (ACLK),
    .rst       (ARESET),
    .src_valid (s.AWVALID),
    .src_ready (s.AWREADY),
    .src_data  (aw_in),
    .dst_valid (m.AWVALID),
    .dst_ready (m.AWREADY),
    .dst_data  (aw_out),
    .lvl       (lvl_aw)
  );

  // Write data: s -> m
  assign w_in = {s.WID, s.WDATA, s.WSTRB, s.WLAST, s.WUSER};
  assign {m.WID, m.WDATA, m.WSTRB, m.WLAST, m.WUSER} = w_out;

  axi4_chan_fifo #(.WIDTH(W_PW), .DEPTH(WD)) u_w (
    .clk       (ACLK),
    .rst       (ARESET),
    .src_valid (s.WVALID),
    .src_ready (s.WREADY),
    .src_data  (w_in),
    .dst_valid (m.WVALID),
    .dst_ready (m.WREADY),
    .dst_data  (w_out),
    .lvl       (lvl_w)
  );

  // Write response: m -> s
  assign b_in = {m.BID, m.BRESP, m.BUSER};
  assign {s.BID, s.BRESP, s.BUSER} = b_out;

  axi4_chan_fifo #(.WIDTH(B_PW), .DEPTH(BD)) u_b (
    .clk       (ACLK),
    .rst       (ARESET),
    .src_valid (m.BVALID),
    .src_ready (m.BREADY),
    .src_data  (b_in),
    .dst_valid (s.BVALID),
    .dst_ready (s.BREADY),
    .dst_data  (b_out),
    .lvl       (lvl_b)
  );

  // Read address: s -> m
  assign ar_in = {s.ARID, s.ARADDR, s.ARREGION, s.ARLEN, s.ARSIZE, s.ARBURST, s.ARLOCK,
                  s.ARCACHE, s.ARPROT, s.ARQOS, s.ARUSER};
  assign {m.ARID, m.ARADDR, m.ARREGION, m.ARLEN, m.ARSIZE, m.ARBURST, m.ARLOCK,
          m.ARCACHE, m.ARPROT, m.ARQOS, m.ARUSER} = ar_out;

  axi4_chan_fifo #(.WIDTH(AR_PW), .DEPTH(ARD)) u_ar (
    .clk       (ACLK),
    .rst       (ARESET),
    .src_valid (s.ARVALID),
    .src_ready (s.ARREADY),
    .src_data  (ar_in),
    .dst_valid (m.ARVALID),
    .dst_ready (m.ARREADY),
    .dst_data  (ar_out),
    .lvl       (lvl_ar)
  );

  // Read data: m -> s
  assign r_in = {m.RID, m.RDATA, m.RRESP, m.RLAST, m.RUSER};
  assign {s.RID, s.RDATA, s.RRESP, s.RLAST, s.RUSER} = r_out;

  axi4_chan_fifo #(.WIDTH(R_PW), .DEPTH(RD)) u_r (
    .clk       (ACLK),
    .rst       (ARESET),
    .src_valid (m.RVALID),
    .src_ready (m.RREADY),
    .src_data  (r_in),
    .dst_valid (s.RVALID),
    .dst_ready (s.RREADY),
    .dst_data  (r_out),
    .lvl       (lvl_r)
  );

endmodule

// File: tb/tb_axi4_buf_slice.sv
// Directed checks on one slice (depths 2/4/3/0/2) and a randomized scoreboard run on a
// second slice covering depths 1/16/2/3/0.
module tb_axi4_buf_slice;
  import axi4_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 1;
  localparam int UW = 1;

  logic ACLK = 1'b0;
  logic ARESET;
  always #5 ACLK = ~ACLK;

  int tests = 0;
  int fails = 0;

  axi4_if #(.AW(AW), .DW(DW), .IW(IW), .UW(UW)) sa ();
  axi4_if #(.AW(AW), .DW(DW), .IW(IW), .UW(UW)) ma ();
  axi4_if #(.AW(AW), .DW(DW), .IW(IW), .UW(UW)) sb ();
  axi4_if #(.AW(AW), .DW(DW), .IW(IW), .UW(UW)) mb ();

  logic [4:0] a_lvl_aw, a_lvl_w, a_lvl_b, a_lvl_ar, a_lvl_r;
  logic [4:0] b_lvl [5];

  axi4_buf_slice #(.AW(AW), .DW(DW), .IW(IW), .UW(UW),
                   .AWD(2), .WD(4), .BD(3), .ARD(0), .RD(2)) dut_a (
    .ACLK(ACLK), .ARESET(ARESET), .s(sa), .m(ma),
    .lvl_aw(a_lvl_aw), .lvl_w(a_lvl_w), .lvl_b(a_lvl_b), .lvl_ar(a_lvl_ar), .lvl_r(a_lvl_r)
  );

  axi4_buf_slice #(.AW(AW), .DW(DW), .IW(IW), .UW(UW),
                   .AWD(1), .WD(16), .BD(2), .ARD(3), .RD(0)) dut_b (
    .ACLK(ACLK), .ARESET(ARESET), .s(sb), .m(mb),
    .lvl_aw(b_lvl[0]), .lvl_w(b_lvl[1]), .lvl_b(b_lvl[2]), .lvl_ar(b_lvl[3]), .lvl_r(b_lvl[4])
  );

  // dut_b channel views indexed 0..4 = AW, W, B, AR, R
  logic [63:0] b_pl [5];
  logic [63:0] b_dpl [5];
  logic        b_sv [5];
  logic        b_sr [5];
  logic        b_dv [5];
  logic        b_dr [5];

  assign {sb.AWID, sb.AWADDR, sb.AWREGION, sb.AWLEN, sb.AWSIZE, sb.AWBURST, sb.AWLOCK,
          sb.AWCACHE, sb.AWPROT, sb.AWQOS, sb.AWUSER} = b_pl[0][62:0];
  assign b_dpl[0] = {1'b0, mb.AWID, mb.AWADDR, mb.AWREGION, mb.AWLEN, mb.AWSIZE, mb.AWBURST,
                     mb.AWLOCK, mb.AWCACHE, mb.AWPROT, mb.AWQOS, mb.AWUSER};
  assign {sb.WID, sb.WDATA, sb.WSTRB, sb.WLAST, sb.WUSER} = b_pl[1][38:0];
  assign b_dpl[1] = {25'b0, mb.WID, mb.WDATA, mb.WSTRB, mb.WLAST, mb.WUSER};
  assign {mb.BID, mb.BRESP, mb.BUSER} = b_pl[2][3:0];
  assign b_dpl[2] = {60'b0, sb.BID, sb.BRESP, sb.BUSER};
  assign {sb.ARID, sb.ARADDR, sb.ARREGION, sb.ARLEN, sb.ARSIZE, sb.ARBURST, sb.ARLOCK,
          sb.ARCACHE, sb.ARPROT, sb.ARQOS, sb.ARUSER} = b_pl[3][62:0];
  assign b_dpl[3] = {1'b0, mb.ARID, mb.ARADDR, mb.ARREGION, mb.ARLEN, mb.ARSIZE, mb.ARBURST,
                     mb.ARLOCK, mb.ARCACHE, mb.ARPROT, mb.ARQOS, mb.ARUSER};
  assign {mb.RID, mb.RDATA, mb.RRESP, mb.RLAST, mb.RUSER} = b_pl[4][36:0];
  assign b_dpl[4] = {27'b0, sb.RID, sb.RDATA, sb.RRESP, sb.RLAST, sb.RUSER};

  assign sb.AWVALID = b_sv[0];
  assign sb.WVALID  = b_sv[1];
  assign mb.BVALID  = b_sv[2];
  assign sb.ARVALID = b_sv[3];
  assign mb.RVALID  = b_sv[4];
  assign mb.AWREADY = b_dr[0];
  assign mb.WREADY  = b_dr[1];
  assign sb.BREADY  = b_dr[2];
  assign mb.ARREADY = b_dr[3];
  assign sb.RREADY  = b_dr[4];
  assign b_sr[0] = sb.AWREADY;
  assign b_sr[1] = sb.WREADY;
  assign b_sr[2] = mb.BREADY;
  assign b_sr[3] = sb.ARREADY;
  assign b_sr[4] = mb.RREADY;
  assign b_dv[0] = mb.AWVALID;
  assign b_dv[1] = mb.WVALID;
  assign b_dv[2] = sb.BVALID;
  assign b_dv[3] = mb.ARVALID;
  assign b_dv[4] = sb.RVALID;

  logic [63:0] pmask [5];
  logic [63:0] mdl [5][64];
  int          wr [5];
  int          rd [5];
  logic        hs_src [5];
  logic        prev_hold [5];
  logic [63:0] prev_dpl [5];
  logic        drain;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge ACLK);
    #1;
  endtask

  task automatic smp();
    @(negedge ACLK);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pmask[0] = 64'h7FFF_FFFF_FFFF_FFFF;
    pmask[1] = 64'h0000_007F_FFFF_FFFF;
    pmask[2] = 64'h0000_0000_0000_000F;
    pmask[3] = 64'h7FFF_FFFF_FFFF_FFFF;
    pmask[4] = 64'h0000_001F_FFFF_FFFF;
    for (int c = 0; c < 5; c++) begin
      b_pl[c] = '0; b_sv[c] = 1'b0; b_dr[c] = 1'b0;
      wr[c] = 0; rd[c] = 0; hs_src[c] = 1'b0; prev_hold[c] = 1'b0; prev_dpl[c] = '0;
    end
    drain = 1'b0;

    sa.AWVALID = 0; sa.AWID = '0; sa.AWADDR = '0; sa.AWREGION = '0; sa.AWLEN = '0;
    sa.AWSIZE = '0; sa.AWBURST = '0; sa.AWLOCK = 0; sa.AWCACHE = '0; sa.AWPROT = '0;
    sa.AWQOS = '0; sa.AWUSER = '0;
    sa.WVALID = 0; sa.WID = '0; sa.WDATA = '0; sa.WSTRB = 4'hF; sa.WLAST = 0; sa.WUSER = '0;
    sa.ARVALID = 0; sa.ARID = '0; sa.ARADDR = '0; sa.ARREGION = '0; sa.ARLEN = '0;
    sa.ARSIZE = '0; sa.ARBURST = '0; sa.ARLOCK = 0; sa.ARCACHE = '0; sa.ARPROT = '0;
    sa.ARQOS = '0; sa.ARUSER = '0;
    ma.BVALID = 0; ma.BID = '0; ma.BRESP = '0; ma.BUSER = '0;
    ma.RVALID = 0; ma.RID = '0; ma.RDATA = '0; ma.RRESP = '0; ma.RLAST = 0; ma.RUSER = '0;
    ma.AWREADY = 1; ma.WREADY = 0; sa.BREADY = 0; ma.ARREADY = 0; sa.RREADY = 1;

    // Reset state
    ARESET = 1'b1;
    repeat (3) cyc();
    smp();
    chk("rst_lvl_aw", 64'(a_lvl_aw), 64'd0);
    chk("rst_lvl_w", 64'(a_lvl_w), 64'd0);
    chk("rst_lvl_b", 64'(a_lvl_b), 64'd0);
    chk("rst_lvl_r", 64'(a_lvl_r), 64'd0);
    chk("rst_awready", 64'(sa.AWREADY), 64'd0);
    chk("rst_wready", 64'(sa.WREADY), 64'd0);
    chk("rst_bready", 64'(ma.BREADY), 64'd0);
    chk("rst_rready", 64'(ma.RREADY), 64'd0);
    chk("rst_awvalid", 64'(ma.AWVALID), 64'd0);
    chk("rst_bvalid", 64'(sa.BVALID), 64'd0);
    cyc();
    ARESET = 1'b0;
    smp();
    chk("rel_awready_pre", 64'(sa.AWREADY), 64'd0);
    cyc();
    smp();
    chk("rel_awready", 64'(sa.AWREADY), 64'd1);
    chk("rel_wready", 64'(sa.WREADY), 64'd1);
    chk("rel_bready", 64'(ma.BREADY), 64'd1);
    chk("rel_rready", 64'(ma.RREADY), 64'd1);

    // Single AW beat through depth 2
    cyc();
    sa.AWVALID = 1; sa.AWID = 1'b1; sa.AWADDR = 32'h1000; sa.AWLEN = 8'd3; sa.AWSIZE = 3'd2;
    sa.AWBURST = BURST_INCR; sa.AWREGION = 4'h5; sa.AWCACHE = 4'h3; sa.AWPROT = 3'h2;
    sa.AWQOS = 4'h9; sa.AWUSER = 1'b1;
    smp();
    chk("aw_lvl_before", 64'(a_lvl_aw), 64'd0);
    chk("aw_mvalid_before", 64'(ma.AWVALID), 64'd0);
    cyc();
    sa.AWVALID = 0; sa.AWADDR = 32'h0; sa.AWLEN = 8'd0; sa.AWID = 1'b0;
    smp();
    chk("aw_mvalid", 64'(ma.AWVALID), 64'd1);
    chk("aw_addr", 64'(ma.AWADDR), 64'h1000);
    chk("aw_len", 64'(ma.AWLEN), 64'd3);
    chk("aw_id", 64'(ma.AWID), 64'd1);
    chk("aw_burst", 64'(ma.AWBURST), 64'(BURST_INCR));
    chk("aw_region", 64'(ma.AWREGION), 64'h5);
    chk("aw_qos", 64'(ma.AWQOS), 64'h9);
    chk("aw_lvl_one", 64'(a_lvl_aw), 64'd1);
    cyc();
    smp();
    chk("aw_lvl_after", 64'(a_lvl_aw), 64'd0);
    chk("aw_mvalid_after", 64'(ma.AWVALID), 64'd0);

    // W fill to depth 4 with downstream stalled, then drain
    for (int i = 0; i < 4; i++) begin
      cyc();
      sa.WVALID = 1; sa.WDATA = 32'hA0 + 32'(i); sa.WLAST = (i == 3);
      smp();
      chk("w_fill_ready", 64'(sa.WREADY), 64'd1);
    end
    cyc();
    sa.WVALID = 0;
    smp();
    chk("w_full_ready", 64'(sa.WREADY), 64'd0);
    chk("w_full_lvl", 64'(a_lvl_w), 64'd4);
    chk("w_head_data", 64'(ma.WDATA), 64'hA0);
    cyc();
    ma.WREADY = 1;
    smp();
    chk("w_full_hold", 64'(sa.WREADY), 64'd0);
    chk("w_head_hold", 64'(ma.WDATA), 64'hA0);
    for (int i = 1; i <= 4; i++) begin
      cyc();
      smp();
      if (i == 1) chk("w_ready_rise", 64'(sa.WREADY), 64'd1);
      if (i < 4) begin
        chk("w_drain_valid", 64'(ma.WVALID), 64'd1);
        chk("w_drain_data", 64'(ma.WDATA), 64'hA0 + 64'(i));
        chk("w_drain_last", 64'(ma.WLAST), 64'(i == 3));
        chk("w_drain_lvl", 64'(a_lvl_w), 64'(4 - i));
      end else begin
        chk("w_empty_valid", 64'(ma.WVALID), 64'd0);
        chk("w_empty_lvl", 64'(a_lvl_w), 64'd0);
      end
    end

    // Streaming 64 R beats through depth 2
    for (int i = 0; i <= 64; i++) begin
      cyc();
      if (i < 64) begin
        ma.RVALID = 1; ma.RDATA = 32'(i); ma.RLAST = (i == 63);
      end else begin
        ma.RVALID = 0; ma.RLAST = 0;
      end
      smp();
      if (i < 64) chk("r_src_ready", 64'(ma.RREADY), 64'd1);
      if (i == 0) begin
        chk("r_first_latency", 64'(sa.RVALID), 64'd0);
      end else begin
        chk("r_valid", 64'(sa.RVALID), 64'd1);
        chk("r_data", 64'(sa.RDATA), 64'(i - 1));
        chk("r_last", 64'(sa.RLAST), 64'(i == 64));
      end
    end
    cyc();
    smp();
    chk("r_idle", 64'(sa.RVALID), 64'd0);

    // B: two beats held, reset pulse, then SLVERR must be the first beat out
    cyc();
    ma.BVALID = 1; ma.BID = 1'b0; ma.BRESP = RESP_OKAY;
    cyc();
    ma.BID = 1'b1; ma.BRESP = RESP_EXOKAY;
    cyc();
    ma.BVALID = 0;
    smp();
    chk("b_lvl_two", 64'(a_lvl_b), 64'd2);
    chk("b_svalid", 64'(sa.BVALID), 64'd1);
    chk("b_head_resp", 64'(sa.BRESP), 64'(RESP_OKAY));
    cyc();
    ARESET = 1'b1;
    cyc();
    ARESET = 1'b0;
    smp();
    chk("b_rst_lvl", 64'(a_lvl_b), 64'd0);
    chk("b_rst_svalid", 64'(sa.BVALID), 64'd0);
    chk("b_rst_bready", 64'(ma.BREADY), 64'd0);
    chk("b_rst_mwvalid", 64'(ma.WVALID), 64'd0);
    chk("b_rst_svalid_r", 64'(sa.RVALID), 64'd0);
    cyc();
    ma.BVALID = 1; ma.BID = 1'b1; ma.BRESP = RESP_SLVERR;
    smp();
    chk("b_rel_bready", 64'(ma.BREADY), 64'd1);
    chk("b_rel_svalid", 64'(sa.BVALID), 64'd0);
    cyc();
    ma.BVALID = 0; sa.BREADY = 1;
    smp();
    chk("b_post_valid", 64'(sa.BVALID), 64'd1);
    chk("b_post_resp", 64'(sa.BRESP), 64'(RESP_SLVERR));
    chk("b_post_id", 64'(sa.BID), 64'd1);
    cyc();
    smp();
    chk("b_post_empty", 64'(sa.BVALID), 64'd0);
    chk("b_post_lvl", 64'(a_lvl_b), 64'd0);

    // AR depth 0: combinational pass-through
    cyc();
    sa.ARVALID = 1; sa.ARADDR = 32'hDEAD_BEEC; sa.ARLEN = 8'd7; sa.ARID = 1'b1;
    smp();
    chk("ar_ready_low", 64'(sa.ARREADY), 64'd0);
    chk("ar_mvalid", 64'(ma.ARVALID), 64'd1);
    chk("ar_addr", 64'(ma.ARADDR), 64'hDEAD_BEEC);
    chk("ar_len", 64'(ma.ARLEN), 64'd7);
    chk("ar_lvl", 64'(a_lvl_ar), 64'd0);
    ma.ARREADY = 1;
    #1;
    chk("ar_ready_follow", 64'(sa.ARREADY), 64'd1);
    cyc();
    sa.ARVALID = 0;
    #1;
    chk("ar_mvalid_off", 64'(ma.ARVALID), 64'd0);

    // Random traffic on dut_b with in-order scoreboard, stability and level checks
    for (int t = 0; t < 10040; t++) begin
      cyc();
      drain = (t >= 10000);
      for (int c = 0; c < 5; c++) begin
        if (!b_sv[c] || hs_src[c]) begin
          b_sv[c] = drain ? 1'b0 : ($urandom_range(0, 3) != 0);
          b_pl[c] = {$urandom(), $urandom()} & pmask[c];
        end
        b_dr[c] = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
      end
      smp();
      for (int c = 0; c < 5; c++) begin
        if (prev_hold[c]) begin
          chk("stable_valid", 64'(b_dv[c]), 64'd1);
          chk("stable_payload", b_dpl[c], prev_dpl[c]);
        end
        chk("lvl_vs_model", 64'(b_lvl[c]), 64'(wr[c] - rd[c]));
        hs_src[c] = b_sv[c] && b_sr[c];
        if (hs_src[c]) begin
          mdl[c][wr[c] % 64] = b_pl[c];
          wr[c]++;
        end
        if (b_dv[c] && b_dr[c]) begin
          chk("pop_has_pending", 64'(wr[c] > rd[c]), 64'd1);
          if (wr[c] > rd[c]) begin
            chk("scoreboard_order", b_dpl[c], mdl[c][rd[c] % 64]);
            rd[c]++;
          end
        end
        prev_hold[c] = b_dv[c] && !b_dr[c];
        prev_dpl[c]  = b_dpl[c];
      end
    end
    for (int c = 0; c < 5; c++) begin
      chk("all_delivered", 64'(wr[c] - rd[c]), 64'd0);
      chk("final_lvl", 64'(b_lvl[c]), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
